// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    DRIVE = 2'd2
  } seg7_state_t;

  // Nibble that makes the shared decoder output its blank pattern.
  localparam logic [3:0] SEG7_BLANK_BCD = 4'hF;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int seg7_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot prescaler and digit index for the scan controller.
// cnt runs 0..SLOT_CYC-1 inside a slot; dig advances when cnt wraps and
// returns to 0 after the last digit. Both are held at 0 while run is low.
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SLOT_CYC   = 50000,
  parameter int GUARD_CYC  = 2,
  localparam int DW = seg7_width(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic [DW-1:0] dig,
  output logic          guard,
  output logic          guard_last,
  output logic          slot_end,
  output logic          frame_end
);

  localparam int CW = seg7_width(SLOT_CYC);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] GUARD_LEN  = CW'(GUARD_CYC);
  localparam logic [CW-1:0] GUARD_END  = CW'(GUARD_CYC - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt;

  assign guard      = (cnt < GUARD_LEN);
  assign guard_last = (cnt == GUARD_END);
  assign slot_end   = (cnt == CNT_LAST);
  assign frame_end  = slot_end && (dig == DIG_LAST);

  // Prescaler and digit index; cleared whenever the scanner is not running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      dig <= '0;
    end else if (!run) begin
      cnt <= '0;
      dig <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      dig <= frame_end ? '0 : dig + DW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered display.
// Optional feature: define SEG7_LZ_BLANK_EN for leading-zero suppression
// (digits above the most significant nonzero nibble stay dark, digit 0 is
// always shown). Without it every digit is driven.
//
// state | meaning
// IDLE  | scanner stopped, display dark, cnt/dig held at 0
// GUARD | first GUARD_CYC cycles of a slot, all digits dark
// DRIVE | rest of the slot, digit dig enabled with its nibble
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SLOT_CYC      = 50000,
  parameter int GUARD_CYC     = 2,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  output logic                    ready,
  output logic [3:0]              bcd,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int DW = seg7_width(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  seg7_state_t state, state_nxt;

  logic          run;
  logic [DW-1:0] dig;
  logic          guard, guard_last, slot_end, frame_end;

  logic [NUM_DIGITS-1:0][3:0] pend_q, disp_q;
  logic                       pend_valid;
  logic                       boundary, commit, show;

  logic [3:0]            bcd_nxt;
  logic [NUM_DIGITS-1:0] an_nxt, an_sel;

  seg7_slot_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SLOT_CYC   (SLOT_CYC),
    .GUARD_CYC  (GUARD_CYC)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .dig        (dig),
    .guard      (guard),
    .guard_last (guard_last),
    .slot_end   (slot_end),
    .frame_end  (frame_end)
  );

  // The frame boundary only counts while actually scanning.
  assign boundary = frame_end && (state == DRIVE);
  // Pending data moves to the display at a boundary, or at once when idle.
  assign commit   = pend_valid && (boundary || (state == IDLE));
  assign ready    = ~pend_valid;

`ifdef SEG7_LZ_BLANK_EN
  logic [DW-1:0] lz_top;

  // Highest digit holding a nonzero nibble; digit 0 when the value is zero.
  always_comb begin
    lz_top = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (disp_q[k] != 4'h0) lz_top = DW'(k);
    end
  end

  assign show = (dig <= lz_top);
`else
  assign show = 1'b1;
`endif

  // Next state, timer run, and next-cycle values for the output registers.
  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    bcd_nxt   = SEG7_BLANK_BCD;
    an_nxt    = AN_OFF;
    an_sel    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << dig;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  state_nxt = GUARD;
        GUARD: begin
          run = 1'b1;
          // !guard recovers if cnt is ever seen past the guard window here.
          if (guard_last || !guard) state_nxt = DRIVE;
        end
        DRIVE: begin
          run = 1'b1;
          if (slot_end) state_nxt = GUARD;
        end
        default: state_nxt = IDLE;
      endcase
    end
    // dig never changes on an edge that enters or stays in DRIVE, so the
    // current index is the one the next cycle will show.
    if ((state_nxt == DRIVE) && show) begin
      bcd_nxt = disp_q[dig];
      an_nxt  = AN_OFF ^ an_sel;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Registered outputs so bcd and an switch on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd        <= SEG7_BLANK_BCD;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      bcd        <= bcd_nxt;
      an         <= an_nxt;
      frame_done <= boundary && en;
    end
  end

  // Pending and display buffers; a full pending buffer blocks new loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_q     <= '0;
      disp_q     <= '0;
    end else if (commit) begin
      disp_q     <= pend_q;
      pend_valid <= 1'b0;
    end else if (load && !pend_valid) begin
      pend_q     <= value;
      pend_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NUM_DIGITS=4, SLOT_CYC=8,
// GUARD_CYC=2, active-low digit enables. Honors SEG7_LZ_BLANK_EN.
module tb_seg7_scan_ctrl;

`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] value;
  logic        ready, frame_done;
  logic [3:0]  bcd;
  logic [3:0]  an;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    bit          en;
    bit          load;
    logic [15:0] value;
    int          cycles;
    logic [3:0]  an;
    logic [3:0]  bcd;
    bit          ready;
    bit          fd;
  } vec_t;

  vec_t vecs[$];

  seg7_scan_ctrl #(
    .NUM_DIGITS    (4),
    .SLOT_CYC      (8),
    .GUARD_CYC     (2),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .value      (value),
    .load       (load),
    .ready      (ready),
    .bcd        (bcd),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string nm, bit e, bit l, logic [15:0] val,
                              int cyc, logic [3:0] ean, logic [3:0] ebcd,
                              bit erdy, bit efd);
    vec_t v;
    v.name = nm; v.en = e; v.load = l; v.value = val; v.cycles = cyc;
    v.an = ean; v.bcd = ebcd; v.ready = erdy; v.fd = efd;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, logic [3:0] ean, logic [3:0] ebcd,
                       bit erdy, bit efd);
    tests++;
    if (an !== ean || bcd !== ebcd || ready !== erdy || frame_done !== efd) begin
      fails++;
      $display("FAIL %s: got an=%b bcd=%h ready=%b fd=%b, want an=%b bcd=%h ready=%b fd=%b",
               nm, an, bcd, ready, frame_done, ean, ebcd, erdy, efd);
    end
  endtask

  // load is held for the first edge of a vector only.
  task automatic apply(input vec_t v);
    en    = v.en;
    value = v.value;
    load  = v.load;
    tick();
    load  = 1'b0;
    for (int i = 1; i < v.cycles; i++) tick();
    check(v.name, v.an, v.bcd, v.ready, v.fd);
  endtask

  initial begin
    // reset release with en=1: guard 2, drive 6 per digit, frame_done at 33
    vecs.push_back(mk("en_g0",        1, 0, 16'h0000, 1, 4'hF, 4'hF, 1, 0));
    vecs.push_back(mk("en_g1",        1, 0, 16'h0000, 1, 4'hF, 4'hF, 1, 0));
    vecs.push_back(mk("d0_first",     1, 0, 16'h0000, 1, 4'hE, 4'h0, 1, 0));
    vecs.push_back(mk("d0_last",      1, 0, 16'h0000, 5, 4'hE, 4'h0, 1, 0));
    vecs.push_back(mk("d1_guard",     1, 0, 16'h0000, 1, 4'hF, 4'hF, 1, 0));
    vecs.push_back(mk("d1_drive",     1, 0, 16'h0000, 2, 4'hD, 4'h0, 1, 0));
    vecs.push_back(mk("d2_drive",     1, 0, 16'h0000, 8, 4'hB, 4'h0, 1, 0));
    vecs.push_back(mk("d3_drive",     1, 0, 16'h0000, 8, 4'h7, 4'h0, 1, 0));
    vecs.push_back(mk("bnd1",         1, 0, 16'h0000, 5, 4'h7, 4'h0, 1, 0));
    vecs.push_back(mk("frame_done1",  1, 0, 16'h0000, 1, 4'hF, 4'hF, 1, 1));
    vecs.push_back(mk("fd_clear",     1, 0, 16'h0000, 1, 4'hF, 4'hF, 1, 0));
    // load 1234 mid-frame, committed at the next boundary
    vecs.push_back(mk("load_1234",    1, 1, 16'h1234, 1, 4'hE, 4'h0, 0, 0));
    vecs.push_back(mk("pend_hold",    1, 0, 16'h0000, 20, 4'hB, 4'h0, 0, 0));
    vecs.push_back(mk("pre_commit",   1, 0, 16'h0000, 9, 4'h7, 4'h0, 0, 0));
    vecs.push_back(mk("commit_1234",  1, 0, 16'h0000, 1, 4'hF, 4'hF, 1, 1));
    vecs.push_back(mk("d0_1234",      1, 0, 16'h0000, 2, 4'hE, 4'h4, 1, 0));
    vecs.push_back(mk("d1_1234",      1, 0, 16'h0000, 8, 4'hD, 4'h3, 1, 0));
    vecs.push_back(mk("d2_1234",      1, 0, 16'h0000, 8, 4'hB, 4'h2, 1, 0));
    vecs.push_back(mk("d3_1234",      1, 0, 16'h0000, 8, 4'h7, 4'h1, 1, 0));
    // load on the boundary cycle, then blocked loads of 9999
    vecs.push_back(mk("to_bnd",       1, 0, 16'h0000, 5, 4'h7, 4'h1, 1, 0));
    vecs.push_back(mk("load_on_bnd",  1, 1, 16'h5678, 1, 4'hF, 4'hF, 0, 1));
    vecs.push_back(mk("blocked1",     1, 1, 16'h9999, 1, 4'hF, 4'hF, 0, 0));
    vecs.push_back(mk("old_d0",       1, 0, 16'h0000, 1, 4'hE, 4'h4, 0, 0));
    vecs.push_back(mk("old_d3",       1, 0, 16'h0000, 24, 4'h7, 4'h1, 0, 0));
    vecs.push_back(mk("blocked2",     1, 1, 16'h9999, 1, 4'h7, 4'h1, 0, 0));
    vecs.push_back(mk("to_bnd2",      1, 0, 16'h0000, 4, 4'h7, 4'h1, 0, 0));
    vecs.push_back(mk("commit_5678",  1, 0, 16'h0000, 1, 4'hF, 4'hF, 1, 1));
    vecs.push_back(mk("d0_5678",      1, 0, 16'h0000, 2, 4'hE, 4'h8, 1, 0));
    vecs.push_back(mk("d1_5678",      1, 0, 16'h0000, 8, 4'hD, 4'h7, 1, 0));
    vecs.push_back(mk("d2_5678",      1, 0, 16'h0000, 8, 4'hB, 4'h6, 1, 0));
    vecs.push_back(mk("d3_5678",      1, 0, 16'h0000, 8, 4'h7, 4'h5, 1, 0));
    // enable drop during digit 2, restart at digit 0
    vecs.push_back(mk("to_d2",        1, 0, 16'h0000, 26, 4'hB, 4'h6, 1, 0));
    vecs.push_back(mk("en_drop",      0, 0, 16'h0000, 1, 4'hF, 4'hF, 1, 0));
    vecs.push_back(mk("idle_hold",    0, 0, 16'h0000, 3, 4'hF, 4'hF, 1, 0));
    vecs.push_back(mk("re_en_guard",  1, 0, 16'h0000, 1, 4'hF, 4'hF, 1, 0));
    vecs.push_back(mk("re_en_d0",     1, 0, 16'h0000, 2, 4'hE, 4'h8, 1, 0));
    // idle load commits on the next cycle; nibble B passes through
    vecs.push_back(mk("idle_again",   0, 0, 16'h0000, 1, 4'hF, 4'hF, 1, 0));
    vecs.push_back(mk("idle_load",    0, 1, 16'h4B21, 1, 4'hF, 4'hF, 0, 0));
    vecs.push_back(mk("idle_commit",  0, 0, 16'h0000, 1, 4'hF, 4'hF, 1, 0));
    vecs.push_back(mk("show_d0",      1, 0, 16'h0000, 3, 4'hE, 4'h1, 1, 0));
    vecs.push_back(mk("show_d1",      1, 0, 16'h0000, 8, 4'hD, 4'h2, 1, 0));
    vecs.push_back(mk("show_d2_hex",  1, 0, 16'h0000, 8, 4'hB, 4'hB, 1, 0));

    rst = 1'b1; en = 1'b1; load = 1'b0; value = 16'h0000;
    #2;
    check("reset", 4'hF, 4'hF, 1'b1, 1'b0);
    tick();
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // asynchronous reset mid-frame with a pending load
    apply(mk("pend_before_rst", 1, 1, 16'h1111, 1, 4'hB, 4'hB, 0, 0));
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", 4'hF, 4'hF, 1'b1, 1'b0);
    rst = 1'b0;
    apply(mk("rst_d0_zero",   1, 0, 16'h0000, 3, 4'hE, 4'h0, 1, 0));
    apply(mk("rst_no_commit", 1, 0, 16'h0000, 30, 4'hF, 4'hF, 1, 1));
    apply(mk("rst_d0_still0", 1, 0, 16'h0000, 2, 4'hE, 4'h0, 1, 0));

    // leading zeros: suppressed with SEG7_LZ_BLANK_EN, shown otherwise
    apply(mk("lz_idle",     0, 0, 16'h0000, 1, 4'hF, 4'hF, 1, 0));
    apply(mk("lz_load42",   0, 1, 16'h0042, 1, 4'hF, 4'hF, 0, 0));
    apply(mk("lz_commit42", 0, 0, 16'h0000, 1, 4'hF, 4'hF, 1, 0));
    apply(mk("lz42_d0",     1, 0, 16'h0000, 3, 4'hE, 4'h2, 1, 0));
    apply(mk("lz42_d1",     1, 0, 16'h0000, 8, 4'hD, 4'h4, 1, 0));
    apply(mk("lz42_d2",     1, 0, 16'h0000, 8, LZ ? 4'hF : 4'hB, LZ ? 4'hF : 4'h0, 1, 0));
    apply(mk("lz42_d3",     1, 0, 16'h0000, 8, LZ ? 4'hF : 4'h7, LZ ? 4'hF : 4'h0, 1, 0));
    apply(mk("lz_idle0",    0, 0, 16'h0000, 1, 4'hF, 4'hF, 1, 0));
    apply(mk("lz_load0",    0, 1, 16'h0000, 1, 4'hF, 4'hF, 0, 0));
    apply(mk("lz_commit0",  0, 0, 16'h0000, 1, 4'hF, 4'hF, 1, 0));
    apply(mk("lz0_d0",      1, 0, 16'h0000, 3, 4'hE, 4'h0, 1, 0));
    apply(mk("lz0_d1",      1, 0, 16'h0000, 8, LZ ? 4'hF : 4'hD, LZ ? 4'hF : 4'h0, 1, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode/common-cathode 7-segment digits that share one BCD-to-segment decoder. It holds a multi-digit BCD display value, steps through the digits at a programmable refresh rate, and for each digit presents that digit's BCD nibble to the shared decoder while enabling only that digit's common line. Guard gaps between digits suppress ghosting. Display updates are double-buffered so that a new value never changes mid-frame.

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits (2..8).
- `SLOT_CYC`, 50000: clock cycles per digit slot (guard included); must be > `GUARD_CYC`.
- `GUARD_CYC`, 2: blanked cycles at the start of every slot (≥1).
- `AN_ACTIVE_LOW`, 1: 1 = digit enables are active-low; 0 = active-high.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: scan enable; when low, the display is dark and the scanner is idle.
- `value` in 4*NUM_DIGITS: BCD digits; nibble k drives digit k (digit 0 is least significant).
- `load` in 1: request to write `value` into the pending buffer.
- `ready` out 1: pending buffer free; a load is accepted only when `load && ready`.
- `bcd` out 4: nibble sent to the shared decoder; 4'hF while blanked, so the decoder outputs its default pattern.
- `an` out NUM_DIGITS: digit common enables; at most one is active.
- `frame_done` out 1: one-cycle pulse at the end of the last digit's slot.

## Operation
- Prescaler `cnt` counts 0..SLOT_CYC-1 and then wraps. Digit index `dig` counts 0..NUM_DIGITS-1 and advances when `cnt` wraps. `dig` wraps from NUM_DIGITS-1 to 0.
- State machine:
  - IDLE: entered on reset or when `en`=0. `cnt`=0, `dig`=0, `an` all inactive, `bcd`=4'hF.
  - IDLE → GUARD when `en`=1.
  - GUARD: occupies `cnt` < GUARD_CYC. `an` all inactive, `bcd`=4'hF.
  - GUARD → DRIVE when `cnt`=GUARD_CYC-1.
  - DRIVE: `an[dig]` is active and `bcd` = display nibble `dig`.
  - DRIVE → GUARD at `cnt`=SLOT_CYC-1, with `dig` advancing.
  - Any state → IDLE whenever `en`=0 at a clock edge. The next `en`=1 restarts at digit 0 in GUARD.
- Buffers:
  - `load && ready` copies `value` to the pending buffer and drops `ready` on the next cycle.
  - At a frame boundary (`cnt`=SLOT_CYC-1 and `dig`=NUM_DIGITS-1), if pending is valid it is copied to the display buffer and `ready` rises on the following cycle.
  - A load accepted on the boundary cycle itself is committed at the next boundary, not the current one.
  - While in IDLE, a pending value commits on the next cycle instead of waiting for a boundary.
  - `load` while `ready`=0 is ignored; the pending buffer is not overwritten.
- `frame_done` pulses on the cycle after each frame boundary, coincident with the display commit. It does not pulse in IDLE.
- BCD nibbles above 9 are passed through unchanged; the decoder blanks them.
- Reset values: `cnt`=0, `dig`=0, display=0, pending invalid, `ready`=1, `frame_done`=0, `an` all inactive, `bcd`=4'hF.
- Reset asserted mid-frame forces IDLE immediately (asynchronously) and discards any pending value.

## Timing
- `bcd` and `an` are registered and change on the same edge, so there is no decoder/enable skew beyond the decoder's combinational delay.
- First active `an` appears GUARD_CYC+1 cycles after `en` rises.
- Each digit is active for SLOT_CYC−GUARD_CYC cycles per frame. The frame length is NUM_DIGITS*SLOT_CYC cycles.
- Load-to-display latency ranges from 1 cycle (IDLE) to NUM_DIGITS*SLOT_CYC+1 cycles (load on the boundary cycle).

## Configuration
- `SEG7_LZ_BLANK_EN`:
  - Defined: leading-zero suppression. Every digit above the most significant nonzero display nibble drives `bcd`=4'hF with its `an` inactive during its slot. Digit 0 is always shown, so a value of 0 displays "0". Slot timing is unchanged.
  - Undefined: all digits are always driven, including leading zeros.

## Structure
- Shared package `seg7_pkg` holds:
  - the state enum (IDLE, GUARD, DRIVE);
  - the constant `SEG7_BLANK_BCD` = 4'hF;
  - a width function for `cnt`/`dig` ($clog2 with a minimum of 1).
- One sub-module, `seg7_slot_timer`, contains the prescaler and digit index. It outputs `dig`, `guard`, `slot_end` and `frame_end`. The FSM, buffers and output registers stay in the top module.

## Test plan
Unless noted, tests use `NUM_DIGITS`=4, `SLOT_CYC`=8, `GUARD_CYC`=2 and `AN_ACTIVE_LOW`=1.
- **Reset and enable:** Release reset with `en`=1 and no load. → `an` = 4'b1111 for 2 cycles, then `an` = 4'b1110 with `bcd`=0 for 6 cycles. Digits 1..3 follow in order. `frame_done` pulses at cycle 33.
- **Load:** Load 16'h1234 while idle-enabled mid-frame. → `ready`=0 until the commit. After the next boundary, digit 0 shows `bcd`=4, digit 1 shows 3, digit 2 shows 2, digit 3 shows 1.
- **Boundary and blocked loads:** Load 16'h5678 exactly on the boundary cycle, then pulse `load` with 16'h9999 while `ready`=0. → The old value is shown for one more full frame, then 5678. 9999 is never displayed.
- **Enable drop:** Drop `en` during digit 2 DRIVE. → `an`=4'b1111 and `bcd`=4'hF on the next edge. Re-raising `en` restarts at digit 0 in GUARD.
- **Reset mid-frame:** Assert `rst` asynchronously mid-frame with a pending load. → All outputs take their reset values immediately, `ready`=1 and the display reads 0.
- **Leading-zero suppression:** With `SEG7_LZ_BLANK_EN` defined, load 16'h0042. → Digits 2 and 3 stay dark with `bcd`=4'hF. Digits 0 and 1 show 2 and 4. Loading 16'h0000 shows "0" on digit 0 only.
